// File: rtl/psum_pkg.sv
// rtl/psum_pkg.sv - default sizes and pointer width for the psum deskew FIFO
package psum_pkg;

   localparam int COL_DEFAULT     = 8;
   localparam int PSUM_BW_DEFAULT = 16;
   localparam int DEPTH_DEFAULT   = 16;
   localparam int PTR_W           = $clog2(DEPTH_DEFAULT);

endpackage

// File: rtl/psum_col_fifo.sv
// rtl/psum_col_fifo.sv - one column FWFT FIFO; PSUM_RELU_EN clamps negative words to zero on write
module psum_col_fifo
   import psum_pkg::*;
#(
   parameter int psum_bw = PSUM_BW_DEFAULT,
   parameter int depth   = DEPTH_DEFAULT,
   parameter int aw      = PTR_W
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               wr,
   input  logic               pop,
   input  logic [psum_bw-1:0] din,
   output logic [psum_bw-1:0] dout,
   output logic               empty,
   output logic               full,
   output logic               drop
);

   localparam logic [aw:0] FULL_CNT = (aw+1)'(depth);

   logic [psum_bw-1:0] mem [depth];
   logic [aw-1:0]      wr_ptr;
   logic [aw-1:0]      rd_ptr;
   logic [aw:0]        count;
   logic               push;
   logic [psum_bw-1:0] wdata;

   assign full  = (count == FULL_CNT);
   assign empty = (count == '0);
   // a pop on the same edge frees the slot, so a full column can still take a write
   assign push  = wr && (!full || pop);
   assign drop  = wr && full && !pop;
   assign dout  = mem[rd_ptr];

`ifdef PSUM_RELU_EN
   assign wdata = din[psum_bw-1] ? '0 : din;
`else
   assign wdata = din;
`endif

   // storage is not reset; only pointers and count define what is live
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= wdata;
   end

   // pointer and occupancy bookkeeping; pointers wrap naturally at depth
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/psum_deskew_fifo.sv
// rtl/psum_deskew_fifo.sv - realigns skewed per-column psums into whole rows; PSUM_RELU_EN enables write-path ReLU
module psum_deskew_fifo
   import psum_pkg::*;
#(
   parameter int col     = COL_DEFAULT,
   parameter int psum_bw = PSUM_BW_DEFAULT,
   parameter int depth   = DEPTH_DEFAULT
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [psum_bw*col-1:0] in_s,
   input  logic [col-1:0]         wr,
   input  logic                   rd,
   output logic [psum_bw*col-1:0] out,
   output logic                   o_valid,
   output logic                   o_full,
   output logic                   o_overflow
);

   logic [col-1:0] empty;
   logic [col-1:0] full;
   logic [col-1:0] drop;
   logic           pop;

   // a row is ready only once the most-delayed column has landed
   assign o_valid = ~|empty;
   assign o_full  = |full;
   assign pop     = rd && o_valid;

   // sticky record that some column lost a write; only reset clears it
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)     o_overflow <= 1'b0;
      else if (|drop) o_overflow <= 1'b1;
   end

   for (genvar i = 0; i < col; i++) begin : g_col
      psum_col_fifo #(
         .psum_bw (psum_bw),
         .depth   (depth),
         .aw      ($clog2(depth))
      ) u_col (
         .clk   (clk),
         .reset (reset),
         .wr    (wr[i]),
         .pop   (pop),
         .din   (in_s[psum_bw*i +: psum_bw]),
         .dout  (out[psum_bw*i +: psum_bw]),
         .empty (empty[i]),
         .full  (full[i]),
         .drop  (drop[i])
      );
   end

endmodule

// File: tb/tb_psum_deskew_fifo.sv
// tb/tb_psum_deskew_fifo.sv - vector table plus queue scoreboard for psum_deskew_fifo
module tb_psum_deskew_fifo;

   localparam int COL   = 8;
   localparam int BW    = 16;
   localparam int DEPTH = 16;

   logic                clk = 1'b0;
   logic                reset;
   logic [BW*COL-1:0]   in_s;
   logic [COL-1:0]      wr;
   logic                rd;
   logic [BW*COL-1:0]   out;
   logic                o_valid;
   logic                o_full;
   logic                o_overflow;

   int total  = 0;
   int passed = 0;

   logic [BW-1:0] q [COL][$];
   logic          m_ovf;

   typedef struct {
      string          name;
      logic [COL-1:0] w;
      logic           r;
      logic [BW-1:0]  val;
      logic           spread;
      logic           exp_valid;
      logic           exp_full;
   } vec_t;

   vec_t vt [13];

   always #5 clk = ~clk;

   psum_deskew_fifo #(.col(COL), .psum_bw(BW), .depth(DEPTH)) dut (
      .clk        (clk),
      .reset      (reset),
      .in_s       (in_s),
      .wr         (wr),
      .rd         (rd),
      .out        (out),
      .o_valid    (o_valid),
      .o_full     (o_full),
      .o_overflow (o_overflow)
   );

   function automatic logic [BW-1:0] relu(input logic [BW-1:0] x);
`ifdef PSUM_RELU_EN
      return x[BW-1] ? '0 : x;
`else
      return x;
`endif
   endfunction

   function automatic logic [BW*COL-1:0] row(input logic [BW-1:0] v, input logic spread);
      logic [BW*COL-1:0] r;
      for (int i = 0; i < COL; i++) r[i*BW +: BW] = spread ? v + BW'(i) : v;
      return r;
   endfunction

   function automatic bit m_valid();
      for (int i = 0; i < COL; i++) if (q[i].size() == 0) return 1'b0;
      return 1'b1;
   endfunction

   function automatic bit m_full();
      for (int i = 0; i < COL; i++) if (q[i].size() == DEPTH) return 1'b1;
      return 1'b0;
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   task automatic check_model(input string tag);
      check({tag, "_valid"}, 32'(o_valid), 32'(m_valid()));
      check({tag, "_full"}, 32'(o_full), 32'(m_full()));
      check({tag, "_ovf"}, 32'(o_overflow), 32'(m_ovf));
      if (m_valid())
         for (int i = 0; i < COL; i++)
            check($sformatf("%s_out%0d", tag, i), 32'(out[i*BW +: BW]), 32'(q[i][0]));
   endtask

   task automatic step(input logic [COL-1:0] w, input logic r, input logic [BW*COL-1:0] d);
      bit mpop;
      mpop = r && m_valid();
      wr   = w;
      rd   = r;
      in_s = d;
      @(posedge clk);
      if (mpop) for (int i = 0; i < COL; i++) q[i].delete(0);
      for (int i = 0; i < COL; i++)
         if (w[i]) begin
            if (q[i].size() < DEPTH) q[i].push_back(relu(d[i*BW +: BW]));
            else m_ovf = 1'b1;
         end
      #1;
      wr = '0;
      rd = 1'b0;
   endtask

   initial begin
      logic [BW*COL-1:0] d;
      reset = 1'b0;
      wr    = '0;
      rd    = 1'b0;
      in_s  = '0;
      m_ovf = 1'b0;

      #1;
      check("rst_valid", 32'(o_valid), 32'd0);
      check("rst_full", 32'(o_full), 32'd0);
      check("rst_ovf", 32'(o_overflow), 32'd0);
      #11 reset = 1'b1;

      for (int j = 0; j < COL; j++)
         vt[j] = '{$sformatf("skew%0d", j), COL'(1 << j), 1'b0, 16'h0A5A, 1'b0, (j == COL-1), 1'b0};
      vt[8]  = '{"skew_pop",  8'h00, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0};
      vt[9]  = '{"nv_wr7",    8'h7F, 1'b0, 16'h0300, 1'b1, 1'b0, 1'b0};
      vt[10] = '{"nv_rd",     8'h00, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0};
      vt[11] = '{"nv_col7",   8'h80, 1'b0, 16'h0300, 1'b1, 1'b1, 1'b0};
      vt[12] = '{"nv_pop",    8'h00, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0};

      for (int n = 0; n < 13; n++) begin
         step(vt[n].w, vt[n].r, row(vt[n].val, vt[n].spread));
         check({vt[n].name, "_tv"}, 32'(o_valid), 32'(vt[n].exp_valid));
         check({vt[n].name, "_tf"}, 32'(o_full), 32'(vt[n].exp_full));
         check_model(vt[n].name);
         if (n == COL-1)
            for (int i = 0; i < COL; i++)
               check($sformatf("skew_k%0d", i), 32'(out[i*BW +: BW]), 32'h0A5A);
      end

      for (int r = 0; r < DEPTH; r++) begin
         step('1, 1'b0, row(16'h1000 + BW'(r * 16'h10), 1'b1));
         if (r == DEPTH-2) check("fill_not_full", 32'(o_full), 32'd0);
      end
      check("fill_full", 32'(o_full), 32'd1);
      check("fill_no_ovf", 32'(o_overflow), 32'd0);
      check_model("fill");

      step('1, 1'b1, row(16'h2000, 1'b1));
      check("rw_full", 32'(o_full), 32'd1);
      check("rw_no_ovf", 32'(o_overflow), 32'd0);
      check("rw_head", 32'(out[BW-1:0]), 32'h1010);
      check_model("rw");

      step(8'h01, 1'b0, row(16'h3000, 1'b1));
      check("ovf_set", 32'(o_overflow), 32'd1);
      check("ovf_head", 32'(out[BW-1:0]), 32'h1010);
      check_model("ovf");

      for (int r = 0; r < DEPTH; r++) begin
         step('0, 1'b1, '0);
         check_model($sformatf("drain%0d", r));
      end
      check("drain_empty", 32'(o_valid), 32'd0);

      d = '0;
      d[BW-1:0]    = 16'hFFF6;
      d[2*BW-1:BW] = 16'h0005;
      step('1, 1'b0, d);
`ifdef PSUM_RELU_EN
      check("relu_neg", 32'(out[BW-1:0]), 32'h0000);
`else
      check("relu_neg", 32'(out[BW-1:0]), 32'hFFF6);
`endif
      check("relu_pos", 32'(out[2*BW-1:BW]), 32'h0005);
      check_model("relu");

      for (int r = 0; r < DEPTH-1; r++) step('1, 1'b0, row(16'h4000 + BW'(r * 16'h10), 1'b1));
      check("pre_rst_full", 32'(o_full), 32'd1);
      check_model("pre_rst");

      #3 reset = 1'b0;
      #1;
      check("arst_valid", 32'(o_valid), 32'd0);
      check("arst_full", 32'(o_full), 32'd0);
      check("arst_ovf", 32'(o_overflow), 32'd0);
      for (int i = 0; i < COL; i++) q[i].delete();
      m_ovf = 1'b0;
      #2 reset = 1'b1;
      check("rel_empty", 32'(o_valid), 32'd0);

      step('1, 1'b0, row(16'h5000, 1'b1));
      check("first_wr_valid", 32'(o_valid), 32'd1);
      check_model("first_wr");
      step('0, 1'b1, '0);
      check("final_empty", 32'(o_valid), 32'd0);
      check_model("final");

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/psum_deskew_fifo.md
PSUM_DESKEW_FIFO -- requirements
Module: psum_deskew_fifo

Interface
REQ-001 SHALL have parameter col, default 8, meaning number of array columns received.
REQ-002 SHALL have parameter psum_bw, default 16, meaning width of one signed partial sum.
REQ-003 SHALL have parameter depth, default 16, meaning entries per column FIFO (power of two, 2 or more).
REQ-004 SHALL have port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1, meaning asynchronous active-low reset (0 = reset asserted).
REQ-006 SHALL have port in_s, input, psum_bw*col, meaning psums from the array bottom row; column i occupies bits [psum_bw*(i+1)-1 : psum_bw*i].
REQ-007 SHALL have port wr, input, col, meaning per-column write strobe, driven by the row valid bits (skewed one cycle per column).
REQ-008 SHALL have port rd, input, 1, meaning pop one aligned word from all columns.
REQ-009 SHALL have port out, output, psum_bw*col, meaning aligned head word, using the same column packing as in_s.
REQ-010 SHALL have port o_valid, output, 1, meaning every column FIFO is non-empty.
REQ-011 SHALL have port o_full, output, 1, meaning at least one column FIFO is full.
REQ-012 SHALL have port o_overflow, output, 1, meaning a sticky flag recording that a write was dropped.

Function
REQ-013 SHALL keep, per column, an independent FIFO with a write pointer, read pointer and occupancy count of width log2(depth)+1.
REQ-014 SHALL accept a write to column i when wr[i]=1 AND (count[i]<depth OR a pop occurs on the same edge).
REQ-015 SHALL drop a write to a full column with no pop that edge, leave that column's contents unchanged, and set o_overflow.
REQ-016 SHALL assert o_valid combinationally as the AND of (count[i]!=0) over all columns.
REQ-017 SHALL pop all columns simultaneously, incrementing every read pointer and decrementing every count, only when rd=1 and o_valid=1.
REQ-018 SHALL ignore rd when o_valid=0, with no pointer or count change.
REQ-019 SHALL present out in first-word-fall-through form: out is the head entry of each column whenever o_valid=1, with zero read latency.
REQ-020 SHALL make write-to-visible latency 1 cycle: a word written at edge N appears at the head at edge N if the FIFO was empty.
REQ-021 SHALL leave count[i] unchanged on a simultaneous accepted write and pop in column i, with both pointers advancing.
REQ-022 SHALL wrap pointers modulo depth with no bubble.
REQ-023 SHALL drive out as don't-care while o_valid=0; it is not required to be zero.
REQ-024 SHALL store psums unchanged, with no width change or arithmetic, except as set by REQ-029.

Reset
REQ-025 SHALL clear all pointers and counts, deassert o_valid (0), deassert o_full (0) and clear o_overflow (0) immediately when reset=0, independent of clk.
REQ-026 SHALL abandon any in-flight partial row on reset assertion mid-operation; the storage array is not required to be cleared.
REQ-027 SHALL clear o_overflow only by reset.
REQ-028 SHALL accept a write on the first rising edge after reset deasserts.

Configuration
REQ-029 SHALL, when macro PSUM_RELU_EN is defined, apply ReLU on the write path: a column word whose MSB is 1 is stored as zero.
REQ-030 SHALL, when PSUM_RELU_EN is undefined, store the raw two's-complement value; port list and timing are identical in both builds.

Structure
REQ-031 SHALL place in package psum_pkg: the default col, psum_bw and depth values, and the pointer-width constant computed as log2(depth).
REQ-032 SHALL instantiate sub-module psum_col_fifo once per column via generate; it holds storage, pointers, count, full/empty and the ReLU option.
REQ-033 SHALL implement the top-level logic, covering the o_valid AND-reduce, pop broadcast and overflow OR-reduce, outside psum_col_fifo.

Verification
REQ-034 SHALL cover skewed fill: with col=8, write row value k in every column, each column's wr delayed one cycle from the previous -> o_valid rises 1 cycle after the column-7 write and out holds k in all columns.
REQ-035 SHALL cover fill to full: 16 aligned writes with no rd -> o_full=1; a 17th write to column 0 -> o_overflow=1 and the head word is unchanged.
REQ-036 SHALL cover simultaneous read and write: when full, assert rd together with wr=all -> counts stay 16, no overflow, and the next head is the second-written word.
REQ-037 SHALL cover read while not valid: rd=1 with column 7 empty -> no pops, and other columns keep count 1.
REQ-038 SHALL cover ReLU: write 16'hFFF6 (-10) and 16'h0005 -> with PSUM_RELU_EN reads 0 and 5; without it reads 16'hFFF6 and 5.
REQ-039 SHALL cover asynchronous reset: assert reset=0 mid-fill between clock edges -> o_valid, o_full and o_overflow are 0 before the next edge, and the FIFO is empty after release.
